scan_chain_reader: RTL
======================

SCAN_CHAIN_READER -- requirements
Module: scan_chain_reader

Interface
REQ-001 SHALL have parameter: DATAWIDTH, default 16, chain length in bits (legal range >= 2).
REQ-002 SHALL have port: TCK  input  1  scan clock; all state updates on posedge TCK.
REQ-003 SHALL have port: Reset  input  1  reset; one clock, synchronous and active-high.
REQ-004 SHALL have port: Start  input  1  request one capture/shift transaction.
REQ-005 SHALL have port: SkipCapture  input  1  sampled with Start; 1 = shift only, no capture pulse.
REQ-006 SHALL have port: PatternIn  input  DATAWIDTH  word to shift into the chain, sampled with Start.
REQ-007 SHALL have port: ScanOut  input  1  serial data returned from the chain (chain bit 0).
REQ-008 SHALL have port: CaptureDR  output  1  chain capture strobe.
REQ-009 SHALL have port: ShiftDR  output  1  chain shift enable.
REQ-010 SHALL have port: ScanIn  output  1  serial data driven into the chain MSB.
REQ-011 SHALL have port: Busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: DataOut  output  DATAWIDTH  word read from the chain.
REQ-013 SHALL have port: DataValid  output  1  DataOut is valid.
REQ-014 SHALL have port: DataReady  input  1  consumer accepts DataOut.

Function
REQ-015 SHALL implement FSM states IDLE, CAPTURE, SHIFT, HOLD; CaptureDR, ShiftDR, Busy and DataValid decoded from the registered state only (glitch-free).
REQ-016 IDLE: Start=1 at a posedge SHALL latch PatternIn and SkipCapture, clear bit counter, go to CAPTURE (SkipCapture=0) or SHIFT (SkipCapture=1).
REQ-017 CAPTURE SHALL last exactly one cycle with CaptureDR=1, ShiftDR=0, then go to SHIFT.
REQ-018 SHIFT SHALL last exactly DATAWIDTH cycles with ShiftDR=1, CaptureDR=0; bit counter k runs 0..DATAWIDTH-1, width $clog2(DATAWIDTH).
REQ-019 In SHIFT cycle k, ScanIn SHALL equal latched pattern bit k; at the closing posedge, ScanOut SHALL be stored into DataOut bit k.
REQ-020 After the posedge ending SHIFT cycle DATAWIDTH-1, the FSM SHALL go to HOLD; chain then holds PatternIn, DataOut holds pre-shift chain contents (LSB first).
REQ-021 HOLD: DataValid=1, DataOut stable; posedge with DataReady=1 SHALL return to IDLE; DataReady=0 SHALL hold indefinitely.
REQ-022 Latency: Start in cycle 0 -> CaptureDR in cycle 1, ShiftDR cycles 2..DATAWIDTH+1, DataValid from cycle DATAWIDTH+2; with SkipCapture, one cycle earlier.
REQ-023 Start outside IDLE SHALL be ignored (no queueing); Start and DataReady in same HOLD cycle SHALL return to IDLE only, Start not accepted.
REQ-024 ScanIn SHALL be 0 outside SHIFT; DataOut SHALL retain its value after leaving HOLD until the next transaction overwrites it bit by bit.
REQ-025 DataReady outside HOLD SHALL have no effect.

Reset
REQ-026 Reset=1 at a posedge SHALL force IDLE, counter 0, latched pattern 0, DataOut 0; outputs CaptureDR, ShiftDR, ScanIn, Busy, DataValid all 0.
REQ-027 Reset SHALL take priority over Start, DataReady and any in-progress transaction; an aborted transaction produces no DataValid; chain contents are left as-is.

Structure
REQ-028 State encodings (IDLE=0, CAPTURE=1, SHIFT=2, HOLD=3) and the DATAWIDTH default SHALL live in the shared scan package/include scan_defs; no local redefinition.
REQ-029 Block SHALL be flat, no sub-module; counter, FSM and data registers inline.

Verification (bench pairs reader with a DATAWIDTH=16 watch chain on the same TCK)
REQ-030 Chain DataIn=16'hA5C3, Start with PatternIn=16'h1234, SkipCapture=0, DataReady=1 -> CaptureDR cycle 1, ShiftDR cycles 2..17, DataValid cycle 18 with DataOut=16'hA5C3.
REQ-031 Immediately repeat with SkipCapture=1, PatternIn=16'h0000 -> no CaptureDR, DataValid cycle 17, DataOut=16'h1234.
REQ-032 DataReady held 0 for 5 cycles in HOLD -> DataValid and DataOut stable 5 cycles, IDLE one cycle after DataReady=1.
REQ-033 Start pulsed during SHIFT and in the same cycle as DataReady in HOLD -> ignored; exactly one transaction observed.
REQ-034 Reset asserted in SHIFT cycle k=7 -> next cycle IDLE, all outputs 0, DataOut=0, no DataValid.
REQ-035 DATAWIDTH=2 instance, chain DataIn=2'b10, PatternIn=2'b01 -> DataOut=2'b10 at cycle 4, chain holds 2'b01.

Source files
------------

// File: rtl/scan_defs.sv
// -----------------------------------------------------------------------------
// scan_defs
// Shared definitions for the scan-chain reader family.
//   - DATAWIDTH_DEFAULT : default chain length in bits
//   - state_t           : reader FSM state encoding (IDLE=0, CAPTURE=1,
//                         SHIFT=2, HOLD=3)
//   - scan_dbg_t        : registered-state snapshot exposed for checkers
// -----------------------------------------------------------------------------
package scan_defs;

  localparam int DATAWIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Snapshot of the control registers: current state plus the latched
  // SkipCapture flag of the transaction in flight (or the last one).
  typedef struct packed {
    state_t state;
    logic   skip;
  } scan_dbg_t;

endpackage

// File: rtl/scan_chain_reader.sv
// -----------------------------------------------------------------------------
// scan_chain_reader
// Reads a DATAWIDTH-bit scan chain while shifting a new pattern into it.
// A transaction optionally pulses CaptureDR for one cycle, then asserts
// ShiftDR for exactly DATAWIDTH cycles. In shift cycle k the reader drives
// pattern bit k on ScanIn and stores ScanOut (chain bit 0) into DataOut[k].
// When shifting ends the chain holds the new pattern and DataOut holds the
// previous chain contents (LSB first).
//
// Ports
//   TCK          in   scan clock, all state updates on its rising edge
//   Reset        in   synchronous active-high reset
//   Start        in   request one transaction (only honoured in IDLE)
//   SkipCapture  in   sampled with Start; 1 = shift only, no capture pulse
//   PatternIn    in   word shifted into the chain, sampled with Start
//   ScanOut      in   serial data returned from the chain (chain bit 0)
//   CaptureDR    out  chain capture strobe
//   ShiftDR      out  chain shift enable
//   ScanIn       out  serial data into the chain MSB (0 outside SHIFT)
//   Busy         out  high in every state except IDLE
//   DataOut      out  word read from the chain
//   DataValid    out  DataOut is valid (HOLD state)
//   DataReady    in   consumer accepts DataOut
//   DbgInfo      out  registered FSM state and latched skip flag
//
// Output handshake: DataValid/DataReady follow valid/ready semantics. While
// DataValid is high, DataOut is stable and stays so until a rising edge sees
// DataReady high; that edge completes the transfer and returns to IDLE.
// DataValid never drops without that acceptance (except on Reset), and
// DataReady has no effect while DataValid is low.
// -----------------------------------------------------------------------------
module scan_chain_reader
  import scan_defs::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
  input  logic                 TCK,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 SkipCapture,
  input  logic [DATAWIDTH-1:0] PatternIn,
  input  logic                 ScanOut,
  output logic                 CaptureDR,
  output logic                 ShiftDR,
  output logic                 ScanIn,
  output logic                 Busy,
  output logic [DATAWIDTH-1:0] DataOut,
  output logic                 DataValid,
  input  logic                 DataReady,
  output scan_dbg_t            DbgInfo
);

  // Counter width; DATAWIDTH >= 2 keeps this at least one bit.
  localparam int CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATAWIDTH - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [CW-1:0]        r_count;
  logic [DATAWIDTH-1:0] r_pattern;
  logic                 r_skip;
  logic [DATAWIDTH-1:0] r_data;

  // ---------------------------------------------------------------------------
  // Combinational next state and decoded outputs
  // ---------------------------------------------------------------------------
  state_t w_state_next;
  logic   w_capture;
  logic   w_shift;
  logic   w_scan_in;
  logic   w_valid;
  logic   w_busy;
  logic   w_last_bit;

  assign w_last_bit = (r_count == LAST_BIT);

  // Outputs depend on r_state (and the registered counter/pattern) only, so
  // the chain control lines cannot glitch on input changes.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_shift      = 1'b0;
    w_scan_in    = 1'b0;
    w_valid      = 1'b0;
    w_busy       = 1'b1;

    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (Start) begin
          w_state_next = SkipCapture ? SHIFT : CAPTURE;
        end
      end

      CAPTURE: begin
        w_capture    = 1'b1;
        w_state_next = SHIFT;
      end

      SHIFT: begin
        w_shift   = 1'b1;
        w_scan_in = r_pattern[r_count];
        if (w_last_bit) begin
          w_state_next = HOLD;
        end
      end

      HOLD: begin
        w_valid = 1'b1;
        // Start in this cycle is deliberately not looked at: acceptance
        // returns to IDLE only, a new request must come later.
        if (DataReady) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge TCK) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_pattern <= '0;
      r_skip    <= 1'b0;
      r_data    <= '0;
    end else begin
      r_state <= w_state_next;

      case (r_state)
        IDLE: begin
          if (Start) begin
            r_pattern <= PatternIn;
            r_skip    <= SkipCapture;
            r_count   <= '0;
          end
        end

        SHIFT: begin
          // ScanOut is the chain bit that lines up with bit k of the word
          // being read out, sampled at the edge that closes shift cycle k.
          r_data[r_count] <= ScanOut;
          if (w_last_bit) begin
            r_count <= '0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign CaptureDR     = w_capture;
  assign ShiftDR       = w_shift;
  assign ScanIn        = w_scan_in;
  assign Busy          = w_busy;
  assign DataValid     = w_valid;
  assign DataOut       = r_data;
  assign DbgInfo.state = r_state;
  assign DbgInfo.skip  = r_skip;

endmodule
